// File: rtl/rx_dma_packer.sv
// UART receive DMA engine: deserialises rx, buffers bytes in a FIFO and packs
// them little-endian into 8/16/32-bit memory writes, flushing partial words on idle.

module rx_deserializer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       deser_clk_posedge,
    input  logic       rx,
    output logic       latch_data,
    output logic [7:0] data
);
    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic [1:0]    sync_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          latch_q, latch_d;
    logic          rx_s;

    assign rx_s       = sync_q[1];
    assign latch_data = latch_q;
    assign data       = shift_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            state_q <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            latch_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            latch_q <= latch_d;
        end
    end

    // Start bit is re-checked at its midpoint; all later bits are sampled one bit period apart.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        latch_d = 1'b0;
        if (deser_clk_posedge) begin
            case (state_q)
                R_IDLE: begin
                    if (!rx_s) begin
                        state_d = R_START;
                        cnt_d   = '0;
                    end
                end
                R_START: begin
                    if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_d   = '0;
                        shift_d = {rx_s, shift_q[7:1]};
                        if (bit_q == 3'd7) state_d = R_STOP;
                        else               bit_d   = bit_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                        cnt_d   = '0;
                        state_d = R_IDLE;
                        latch_d = rx_s;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

module rx_dma_packer #(
    parameter int         M_WIDTH          = 32,
    parameter logic [1:0] MEM_ACC_8        = 2'b00,
    parameter logic [1:0] MEM_ACC_16       = 2'b01,
    parameter logic [1:0] MEM_ACC_32       = 2'b10,
    parameter int         RX_CLKS_PER_BIT  = 8,
    parameter int         FIFO_DEPTH       = 16,
    parameter int         IDLE_FLUSH_TICKS = 80
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               deser_clk_posedge,
    input  logic               ptr_rst,
    input  logic               circular,
    input  logic [1:0]         pack_mode,
    input  logic [M_WIDTH-1:0] dma_buf_start,
    input  logic [M_WIDTH-1:0] dma_buf_end,
    output logic               dma_buf_full,
    output logic               wrapped,
    output logic               overrun,
    output logic [M_WIDTH-1:0] ptr,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic [M_WIDTH-1:0] mem_addr,
    output logic [1:0]         mem_width,
    output logic [M_WIDTH-1:0] mem_data_out,
    input  logic               rx
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int IW = $clog2(IDLE_FLUSH_TICKS + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_POP   = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic       latch_data;
    logic [7:0] rx_byte;

    rx_deserializer #(
        .CLKS_PER_BIT(RX_CLKS_PER_BIT)
    ) u_deser (
        .clk               (clk),
        .rst               (rst),
        .deser_clk_posedge (deser_clk_posedge),
        .rx                (rx),
        .latch_data        (latch_data),
        .data              (rx_byte)
    );

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [AW:0]        wr_q, rd_q;
    logic [7:0]         fifo_data_q;
    logic               fifo_empty, fifo_full, fifo_read_en, fifo_write;

    logic [1:0]         state_q, state_d;
    logic [M_WIDTH-1:0] ptr_q, ptr_d;
    logic [M_WIDTH-1:0] pack_reg_q, pack_reg_d;
    logic [2:0]         pack_cnt_q, pack_cnt_d;
    logic [IW-1:0]      idle_q, idle_d;
    logic               overrun_q, overrun_d;
    logic               wrapped_q, wrapped_d;
    logic [2:0]         nbytes, step;
    logic [M_WIDTH-1:0] ptr_adv;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

    assign nbytes = (pack_mode == MEM_ACC_32) ? 3'd4 :
                    (pack_mode == MEM_ACC_16) ? 3'd2 : 3'd1;

    assign dma_buf_full = en & ~circular & (ptr_q == dma_buf_end);

    assign fifo_read_en = rst & en & ~ptr_rst & (state_q == S_IDLE) & ~fifo_empty
                          & ~dma_buf_full & (pack_cnt_q < nbytes);
    // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
    assign fifo_write   = rst & en & latch_data & (~fifo_full | fifo_read_en);

    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            wr_q        <= '0;
            rd_q        <= '0;
            fifo_data_q <= '0;
        end else begin
            if (fifo_write)   wr_q <= wr_q + 1'b1;
            if (fifo_read_en) begin
                rd_q        <= rd_q + 1'b1;
                fifo_data_q <= fifo_mem[rd_q[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_write) fifo_mem[wr_q[AW-1:0]] <= rx_byte;
    end

    assign step    = (state_q == S_FLUSH) ? 3'd1 : nbytes;
    assign ptr_adv = ptr_q + {{(M_WIDTH-3){1'b0}}, step};

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        pack_reg_d = pack_reg_q;
        pack_cnt_d = pack_cnt_q;
        wrapped_d  = 1'b0;
        overrun_d  = overrun_q | (latch_data & fifo_full & ~fifo_read_en);
        idle_d     = idle_q;
        if (pack_cnt_q == 3'd0)
            idle_d = '0;
        else if (deser_clk_posedge && idle_q != IW'(IDLE_FLUSH_TICKS))
            idle_d = idle_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (fifo_read_en)
                    state_d = S_POP;
                else if (pack_cnt_q == nbytes)
                    state_d = S_REQ;
                else if (pack_cnt_q != 3'd0 && idle_q == IW'(IDLE_FLUSH_TICKS))
                    state_d = S_FLUSH;
            end
            S_POP: begin
                pack_reg_d[{pack_cnt_q[1:0], 3'b000} +: 8] = fifo_data_q;
                pack_cnt_d = pack_cnt_q + 1'b1;
                idle_d     = '0;
                state_d    = S_IDLE;
            end
            default: begin
                if (mem_ready) begin
                    if (ptr_adv == dma_buf_end) begin
                        ptr_d     = circular ? dma_buf_start : dma_buf_end;
                        wrapped_d = circular;
                    end else begin
                        ptr_d = ptr_adv;
                    end
                    if (state_q == S_REQ) begin
                        pack_reg_d = '0;
                        pack_cnt_d = '0;
                        state_d    = S_IDLE;
                    end else begin
                        pack_reg_d = pack_reg_q >> 8;
                        pack_cnt_d = pack_cnt_q - 1'b1;
                        if (pack_cnt_q == 3'd1) state_d = S_IDLE;
                    end
                end
            end
        endcase

        if (!en) begin
            state_d    = S_IDLE;
            pack_reg_d = '0;
            pack_cnt_d = '0;
            idle_d     = '0;
            wrapped_d  = 1'b0;
            overrun_d  = overrun_q;
            ptr_d      = ptr_q;
        end
        if (ptr_rst) begin
            state_d    = S_IDLE;
            ptr_d      = dma_buf_start;
            pack_reg_d = '0;
            pack_cnt_d = '0;
            idle_d     = '0;
            wrapped_d  = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            pack_reg_q <= '0;
            pack_cnt_q <= '0;
            idle_q     <= '0;
            overrun_q  <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            pack_reg_q <= pack_reg_d;
            pack_cnt_q <= pack_cnt_d;
            idle_q     <= idle_d;
            overrun_q  <= overrun_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign ptr          = ptr_q;
    assign wrapped      = wrapped_q;
    assign overrun      = overrun_q;
    assign mem_req      = (state_q == S_REQ) || (state_q == S_FLUSH);
    assign mem_addr     = ptr_q;
    assign mem_width    = (state_q == S_FLUSH) ? MEM_ACC_8 :
                          (state_q == S_REQ)   ? pack_mode : 2'b00;
    assign mem_data_out = (state_q == S_FLUSH) ? {{(M_WIDTH-8){1'b0}}, pack_reg_q[7:0]} :
                          (state_q == S_REQ)   ? pack_reg_q : '0;
endmodule

// File: tb/tb_rx_dma_packer.sv
// Randomised bench for rx_dma_packer: a UART driver feeds bytes, a memory responder
// records writes, and a queue-based reference model predicts every write and pointer.

module tb_rx_dma_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        deser_clk_posedge = 1'b0;
    logic        ptr_rst = 1'b0;
    logic        circular = 1'b0;
    logic [1:0]  pack_mode = 2'b00;
    logic [31:0] dma_buf_start = '0;
    logic [31:0] dma_buf_end = '0;
    logic        dma_buf_full, wrapped, overrun, mem_req;
    logic [31:0] ptr, mem_addr, mem_data_out;
    logic [1:0]  mem_width;
    logic        mem_ready = 1'b0;
    logic        rx = 1'b1;

    rx_dma_packer #(
        .M_WIDTH(32), .MEM_ACC_8(2'b00), .MEM_ACC_16(2'b01), .MEM_ACC_32(2'b10),
        .RX_CLKS_PER_BIT(8), .FIFO_DEPTH(16), .IDLE_FLUSH_TICKS(80)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .deser_clk_posedge(deser_clk_posedge),
        .ptr_rst(ptr_rst), .circular(circular), .pack_mode(pack_mode),
        .dma_buf_start(dma_buf_start), .dma_buf_end(dma_buf_end),
        .dma_buf_full(dma_buf_full), .wrapped(wrapped), .overrun(overrun), .ptr(ptr),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_width(mem_width), .mem_data_out(mem_data_out), .rx(rx)
    );

    always #5 clk = ~clk;

    int        errors = 0;
    int        checks = 0;
    int        wrap_cnt = 0;
    int        tdiv = 0;
    bit        allow_ready = 1'b0;
    logic [65:0] got_q[$];
    logic [65:0] exp_q[$];
    logic [7:0]  sent_q[$];

    // Oversample tick: one clk cycle in every eight.
    always @(negedge clk) begin
        tdiv = (tdiv + 1) % 8;
        deser_clk_posedge = (tdiv == 0);
    end

    // Memory responder: random accept latency, records each accepted write.
    always @(negedge clk) begin
        if (wrapped === 1'b1) wrap_cnt++;
        if (mem_ready) begin
            mem_ready = 1'b0;
        end else if (mem_req && allow_ready && ($urandom_range(0, 2) == 0)) begin
            mem_ready = 1'b1;
            got_q.push_back({mem_width, mem_addr, mem_data_out});
        end
    end

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Eight ticks per bit; a shortened stop bit keeps back-to-back frames inside the idle-flush window.
    task automatic send_byte(input logic [7:0] b);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (64) @(negedge clk);
        end
        rx = 1'b1;
        repeat (48) @(negedge clk);
    endtask

    task automatic configure(input logic [1:0] mode, input logic [31:0] s, input logic [31:0] e,
                             input logic c);
        @(negedge clk);
        en = 1'b0;
        pack_mode = mode;
        dma_buf_start = s;
        dma_buf_end = e;
        circular = c;
        ptr_rst = 1'b1;
        @(negedge clk);
        ptr_rst = 1'b0;
        en = 1'b1;
        got_q.delete();
        exp_q.delete();
        wrap_cnt = 0;
    endtask

    // Reference: whole words first, then any leftover bytes as single-byte writes.
    task automatic model(input logic [1:0] mode, input logic [31:0] s, input logic [31:0] e,
                         input logic c, output logic [31:0] p, output int wraps,
                         output logic full);
        int nb, i, n;
        logic [31:0] w;
        nb = (mode == 2'b10) ? 4 : (mode == 2'b01) ? 2 : 1;
        n = sent_q.size();
        p = s; i = 0; wraps = 0; full = 1'b0;
        while (!full && i < n) begin
            if (i + nb <= n) begin
                w = '0;
                for (int k = 0; k < nb; k++) w = w | (32'(sent_q[i + k]) << (8 * k));
                exp_q.push_back({mode, p, w});
                p = p + 32'(nb);
                i = i + nb;
            end else begin
                exp_q.push_back({2'b00, p, 24'h0, sent_q[i]});
                p = p + 32'd1;
                i = i + 1;
            end
            if (p == e) begin
                if (c) begin p = s; wraps++; end
                else full = 1'b1;
            end
        end
    endtask

    task automatic compare(input string tag, input logic [31:0] ep, input int ew, input logic ef);
        check({tag, "_count"}, 66'(got_q.size()), 66'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_ptr"}, 66'(ptr), 66'(ep));
        check({tag, "_wraps"}, 66'(wrap_cnt), 66'(ew));
        check({tag, "_full"}, 66'(dma_buf_full), 66'(ef));
    endtask

    task automatic run_case(input string tag, input logic [1:0] mode, input logic [31:0] s,
                            input logic [31:0] e, input logic c);
        logic [31:0] ep;
        int ew;
        logic ef;
        configure(mode, s, e, c);
        model(mode, s, e, c, ep, ew, ef);
        foreach (sent_q[i]) send_byte(sent_q[i]);
        repeat (1600) @(negedge clk);
        compare(tag, ep, ew, ef);
    endtask

    initial begin
        logic [31:0] ep, s, e;
        logic [1:0]  mode;
        int ew, k, nb;
        logic ef;

        repeat (5) @(posedge clk);
        #1;
        check("rst_req", 66'(mem_req), 66'(0));
        check("rst_ptr", 66'(ptr), 66'(0));
        check("rst_overrun", 66'(overrun), 66'(0));
        check("rst_wrapped", 66'(wrapped), 66'(0));
        check("rst_full", 66'(dma_buf_full), 66'(0));
        check("rst_data", 66'(mem_data_out), 66'(0));
        @(negedge clk);
        rst = 1'b1;
        allow_ready = 1'b1;

        sent_q = '{8'h11, 8'h12, 8'h13, 8'h14};
        run_case("lin8", 2'b00, 32'h100, 32'h104, 1'b0);

        sent_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_case("word32", 2'b10, 32'h140, 32'h180, 1'b0);

        sent_q = '{8'h55, 8'h66};
        run_case("flush32", 2'b10, 32'h180, 32'h1C0, 1'b0);

        sent_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_case("circ16", 2'b01, 32'h200, 32'h204, 1'b1);

        for (int t = 0; t < 5; t++) begin
            mode = 2'($urandom_range(0, 2));
            nb = (mode == 2'b10) ? 4 : (mode == 2'b01) ? 2 : 1;
            s = 32'h1000 + (32'($urandom_range(0, 63)) << 4);
            e = s + 32'(nb * $urandom_range(1, 3));
            sent_q.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) sent_q.push_back(8'($urandom));
            run_case($sformatf("rnd%0d", t), mode, s, e, 1'($urandom_range(0, 1)));
        end

        // Overrun: memory stalled, one byte held in the packer plus sixteen in the FIFO.
        configure(2'b00, 32'h400, 32'h500, 1'b0);
        allow_ready = 1'b0;
        sent_q.delete();
        for (int i = 0; i < 19; i++) sent_q.push_back(8'($urandom));
        foreach (sent_q[i]) send_byte(sent_q[i]);
        repeat (200) @(negedge clk);
        check("ovr_set", 66'(overrun), 66'(1));
        void'(sent_q.pop_back());
        void'(sent_q.pop_back());
        model(2'b00, 32'h400, 32'h500, 1'b0, ep, ew, ef);
        allow_ready = 1'b1;
        repeat (1600) @(negedge clk);
        compare("ovr", ep, ew, ef);
        ptr_rst = 1'b1;
        @(negedge clk);
        ptr_rst = 1'b0;
        check("ovr_clear", 66'(overrun), 66'(0));
        check("ovr_ptr_rst", 66'(ptr), 66'(32'h400));

        // Reset while a request is pending.
        configure(2'b00, 32'h300, 32'h310, 1'b0);
        allow_ready = 1'b0;
        send_byte(8'h5A);
        k = 0;
        while (!mem_req && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("rreq_seen", 66'(mem_req), 66'(1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rreq_drop", 66'(mem_req), 66'(0));
        check("rreq_ptr", 66'(ptr), 66'(0));
        @(negedge clk);
        rst = 1'b1;
        allow_ready = 1'b1;
        repeat (800) @(negedge clk);
        check("rreq_nowrite", 66'(got_q.size()), 66'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
